control_unit: RTL and testbench
===============================

CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 SHALL have port: clock  input  1  single system clock, all state changes on rising edge.
REQ-002 SHALL have port: clear  input  1  asynchronous active-low reset.
REQ-003 SHALL have port: IR  input  32  instruction register contents from datapath; opcode IR[31:27].
REQ-004 SHALL have port: stop  input  1  request to halt at the end of the current instruction.
REQ-005 SHALL have outputs, 1 bit each, datapath strobes: PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin, Yin, Zin, Zlowout, Zhighout, HIin, LOin, Gra, Grb, Grc, Rin, Rout.
REQ-006 SHALL have port: alu_op  output  4  ALU operation: ADD=0 SUB=1 AND=2 OR=3 SHR=4 SHRA=5 SHL=6 ROR=7 ROL=8 MUL=9 DIV=10 NEG=11 NOT=12.
REQ-007 SHALL have port: run  output  1  high while executing, low in RST and HALT.
REQ-008 SHALL have port: state  output  4  current state encoding, for debug.

Function
REQ-009 SHALL implement a Moore FSM with states RST=0, T0=1 ... T6=7, HALT=8; one state per clock; all outputs decoded from state and IR only.
REQ-010 SHALL sequence fetch for every instruction: T0 PCout,MARin,IncPC,Zin; T1 Zlowout,PCin,Read,MDRin; T2 MDRout,IRin.
REQ-011 SHALL decode opcode in T3 (IR valid from T3): add 00011, sub 00100, and 00101, or 00110, shr 00111, shra 01000, shl 01001, ror 01010, rol 01011, mul 01111, div 10000, neg 10001, not 10010, nop 11011, halt 11100; any other opcode is illegal.
REQ-012 SHALL, for ALU opcodes, assert T3 Grb,Rout,Yin; T4 Rout plus Grc (binary) or Grb (neg/not), alu_op=op, Zin; T5 Zlowout plus Gra,Rin (non-mul/div) or LOin (mul/div).
REQ-013 SHALL, for mul/div, assert T6 Zhighout,HIin; mul/div instructions take 7 cycles, other ALU instructions 6.
REQ-014 SHALL hold alu_op=0 and all strobes low in every state/opcode combination not listed in REQ-010..REQ-013.
REQ-015 SHALL, for nop, assert nothing in T3 and go to T0 (4 cycles); for halt or illegal opcode, assert nothing in T3 and go to HALT.
REQ-016 SHALL sample stop in the final state of each instruction (T5, T6 for mul/div, T3 for nop); if high, next state is HALT, else T0.
REQ-017 SHALL ignore stop pulses that are not high in that final state; stop and halt opcode together yield HALT.
REQ-018 SHALL remain in HALT, all strobes low, run=0, until clear is asserted.
REQ-019 SHALL go RST -> T0 on the first rising edge after clear deasserts; run=1 from T0 onward.

Reset
REQ-020 SHALL, on clear low, immediately (without clock) enter RST with all strobes 0, alu_op=0, run=0, state=0.
REQ-021 SHALL abort any in-flight instruction on reset; no partial strobe survives into RST.
REQ-022 SHALL restart fetch at T0 after reset; the PC value is the datapath's concern.

Configuration
REQ-023 SHALL, with macro CONTROL_UNIT_MULDIV_EN defined, support mul/div per REQ-012..REQ-013 including state T6.
REQ-024 SHALL, without CONTROL_UNIT_MULDIV_EN, treat opcodes 01111 and 10000 as illegal (T3 -> HALT), never enter T6, never assert HIin, LOin or Zhighout.

Verification
REQ-025 SHALL verify: release clear, IR=0x18918000 (add R1,R2,R3) -> RST,T0..T5, T4 alu_op=0 with Grc,Rout,Zin, T5 Gra,Rin,Zlowout, back in T0 on cycle 7.
REQ-026 SHALL verify: MULDIV_EN defined, IR=0x78000000 (mul) -> T5 LOin,Zlowout; T6 HIin,Zhighout; alu_op=9 in T4; T0 after 7 cycles.
REQ-027 SHALL verify: MULDIV_EN undefined, IR=0x78000000 -> T3 with no strobes, then HALT, run=0, held for 10 cycles.
REQ-028 SHALL verify: IR=0x28000000 (and), stop high only during T1 -> completes T5 then T0 (stop ignored); stop held high through T5 -> HALT.
REQ-029 SHALL verify: clear low mid-T4 -> strobes 0 and state=0 before next edge; after release, T0 on the next edge.
REQ-030 SHALL verify: IR=0xD8000000 (nop) -> T0,T1,T2,T3 then T0; IR=0xE0000000 (halt) -> HALT after T3.

Source files
------------

// File: rtl/control_unit.sv
// control_unit: hardwired Moore sequencer for the simple CPU datapath.
// Ports:
//   clock        rising-edge system clock
//   clear        asynchronous active-low reset
//   IR           instruction register, opcode in IR[31:27]
//   stop         halt request, sampled in the last state of an instruction
//   PCout..Rout  1-bit datapath strobes
//   alu_op       ALU function select, valid in T4 of ALU instructions
//   run          high while executing (T0..T6)
//   state        current state encoding, for debug
// Build option: define CONTROL_UNIT_MULDIV_EN to support mul/div (state T6).
module control_unit (
    input  logic        clock,
    input  logic        clear,
    input  logic [31:0] IR,
    input  logic        stop,
    output logic        PCout,
    output logic        PCin,
    output logic        IncPC,
    output logic        MARin,
    output logic        Read,
    output logic        MDRin,
    output logic        MDRout,
    output logic        IRin,
    output logic        Yin,
    output logic        Zin,
    output logic        Zlowout,
    output logic        Zhighout,
    output logic        HIin,
    output logic        LOin,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        Rout,
    output logic [3:0]  alu_op,
    output logic        run,
    output logic [3:0]  state
);

    typedef enum logic [3:0] {
        RST  = 4'd0,
        T0   = 4'd1,
        T1   = 4'd2,
        T2   = 4'd3,
        T3   = 4'd4,
        T4   = 4'd5,
        T5   = 4'd6,
        T6   = 4'd7,
        HALT = 4'd8
    } state_t;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_SHR  = 4'd4,
        OP_SHRA = 4'd5,
        OP_SHL  = 4'd6,
        OP_ROR  = 4'd7,
        OP_ROL  = 4'd8,
        OP_MUL  = 4'd9,
        OP_DIV  = 4'd10,
        OP_NEG  = 4'd11,
        OP_NOT  = 4'd12
    } alu_t;

    state_t     cur;
    state_t     nxt;
    logic [4:0] opcode;
    logic [3:0] alu_code;
    logic       is_alu;
    logic       is_md;
    logic       is_unary;
    logic       is_nop;
    logic       unused_ir;

    assign opcode    = IR[31:27];
    assign unused_ir = ^IR[26:0];

    // Opcode classification; halt and every unlisted opcode fall to default.
    always_comb begin
        alu_code = OP_ADD;
        is_alu   = 1'b0;
        is_md    = 1'b0;
        is_unary = 1'b0;
        is_nop   = 1'b0;
        case (opcode)
            5'b00011: begin is_alu = 1'b1; alu_code = OP_ADD;  end
            5'b00100: begin is_alu = 1'b1; alu_code = OP_SUB;  end
            5'b00101: begin is_alu = 1'b1; alu_code = OP_AND;  end
            5'b00110: begin is_alu = 1'b1; alu_code = OP_OR;   end
            5'b00111: begin is_alu = 1'b1; alu_code = OP_SHR;  end
            5'b01000: begin is_alu = 1'b1; alu_code = OP_SHRA; end
            5'b01001: begin is_alu = 1'b1; alu_code = OP_SHL;  end
            5'b01010: begin is_alu = 1'b1; alu_code = OP_ROR;  end
            5'b01011: begin is_alu = 1'b1; alu_code = OP_ROL;  end
`ifdef CONTROL_UNIT_MULDIV_EN
            5'b01111: begin
                is_alu   = 1'b1;
                is_md    = 1'b1;
                alu_code = OP_MUL;
            end
            5'b10000: begin
                is_alu   = 1'b1;
                is_md    = 1'b1;
                alu_code = OP_DIV;
            end
`endif
            5'b10001: begin
                is_alu   = 1'b1;
                is_unary = 1'b1;
                alu_code = OP_NEG;
            end
            5'b10010: begin
                is_alu   = 1'b1;
                is_unary = 1'b1;
                alu_code = OP_NOT;
            end
            5'b11011: is_nop = 1'b1;
            default:  ;
        endcase
    end

    // stop is only honoured in the last state of each instruction.
    always_comb begin
        nxt = cur;
        case (cur)
            RST: nxt = T0;
            T0:  nxt = T1;
            T1:  nxt = T2;
            T2:  nxt = T3;
            T3: begin
                if (is_alu)
                    nxt = T4;
                else if (is_nop)
                    nxt = stop ? HALT : T0;
                else
                    nxt = HALT;
            end
            T4:  nxt = T5;
            T5: begin
                if (is_md)
                    nxt = T6;
                else
                    nxt = stop ? HALT : T0;
            end
`ifdef CONTROL_UNIT_MULDIV_EN
            T6:  nxt = stop ? HALT : T0;
`endif
            HALT: nxt = HALT;
            default: nxt = HALT;
        endcase
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear)
            cur <= RST;
        else
            cur <= nxt;
    end

    // Moore decode: strobes depend only on state and IR, so entering RST
    // asynchronously clears every strobe without waiting for a clock.
    always_comb begin
        PCout    = 1'b0;
        PCin     = 1'b0;
        IncPC    = 1'b0;
        MARin    = 1'b0;
        Read     = 1'b0;
        MDRin    = 1'b0;
        MDRout   = 1'b0;
        IRin     = 1'b0;
        Yin      = 1'b0;
        Zin      = 1'b0;
        Zlowout  = 1'b0;
        Zhighout = 1'b0;
        HIin     = 1'b0;
        LOin     = 1'b0;
        Gra      = 1'b0;
        Grb      = 1'b0;
        Grc      = 1'b0;
        Rin      = 1'b0;
        Rout     = 1'b0;
        alu_op   = 4'd0;
        case (cur)
            T0: begin
                PCout = 1'b1;
                MARin = 1'b1;
                IncPC = 1'b1;
                Zin   = 1'b1;
            end
            T1: begin
                Zlowout = 1'b1;
                PCin    = 1'b1;
                Read    = 1'b1;
                MDRin   = 1'b1;
            end
            T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            T3: begin
                if (is_alu) begin
                    Grb  = 1'b1;
                    Rout = 1'b1;
                    Yin  = 1'b1;
                end
            end
            T4: begin
                if (is_alu) begin
                    Rout   = 1'b1;
                    Grc    = !is_unary;
                    Grb    = is_unary;
                    alu_op = alu_code;
                    Zin    = 1'b1;
                end
            end
            T5: begin
                if (is_alu) begin
                    Zlowout = 1'b1;
                    Gra     = !is_md;
                    Rin     = !is_md;
`ifdef CONTROL_UNIT_MULDIV_EN
                    LOin    = is_md;
`endif
                end
            end
`ifdef CONTROL_UNIT_MULDIV_EN
            T6: begin
                if (is_md) begin
                    Zhighout = 1'b1;
                    HIin     = 1'b1;
                end
            end
`endif
            default: ;
        endcase
    end

    assign run   = (cur != RST) && (cur != HALT);
    assign state = cur;

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed plus randomized instruction streams for
// control_unit, checked cycle by cycle against a per-instruction trace model.
module tb_control_unit;

`ifdef CONTROL_UNIT_MULDIV_EN
    localparam bit MD_BUILD = 1'b1;
`else
    localparam bit MD_BUILD = 1'b0;
`endif

    localparam int S_RST  = 0;
    localparam int S_T0   = 1;
    localparam int S_T1   = 2;
    localparam int S_T2   = 3;
    localparam int S_T3   = 4;
    localparam int S_T4   = 5;
    localparam int S_T5   = 6;
    localparam int S_T6   = 7;
    localparam int S_HALT = 8;

    localparam logic [18:0] B_PCOUT  = 19'h1 << 18;
    localparam logic [18:0] B_PCIN   = 19'h1 << 17;
    localparam logic [18:0] B_INCPC  = 19'h1 << 16;
    localparam logic [18:0] B_MARIN  = 19'h1 << 15;
    localparam logic [18:0] B_READ   = 19'h1 << 14;
    localparam logic [18:0] B_MDRIN  = 19'h1 << 13;
    localparam logic [18:0] B_MDROUT = 19'h1 << 12;
    localparam logic [18:0] B_IRIN   = 19'h1 << 11;
    localparam logic [18:0] B_YIN    = 19'h1 << 10;
    localparam logic [18:0] B_ZIN    = 19'h1 << 9;
    localparam logic [18:0] B_ZLO    = 19'h1 << 8;
    localparam logic [18:0] B_ZHI    = 19'h1 << 7;
    localparam logic [18:0] B_HIIN   = 19'h1 << 6;
    localparam logic [18:0] B_LOIN   = 19'h1 << 5;
    localparam logic [18:0] B_GRA    = 19'h1 << 4;
    localparam logic [18:0] B_GRB    = 19'h1 << 3;
    localparam logic [18:0] B_GRC    = 19'h1 << 2;
    localparam logic [18:0] B_RIN    = 19'h1 << 1;
    localparam logic [18:0] B_ROUT   = 19'h1;

    logic        clock;
    logic        clear;
    logic [31:0] IR;
    logic        stop;
    logic        PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin;
    logic        Yin, Zin, Zlowout, Zhighout, HIin, LOin;
    logic        Gra, Grb, Grc, Rin, Rout;
    logic [3:0]  alu_op;
    logic        run;
    logic [3:0]  state;

    int vectors     = 0;
    int miscompares = 0;

    logic [27:0] exp_q[$];
    logic        exp_ends_halt;

    // Opcodes of ALU instructions, listed in alu_op order.
    logic [4:0] alu_ops [13] = '{5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9,
                                 5'd10, 5'd11, 5'd15, 5'd16, 5'd17, 5'd18};

    control_unit dut (
        .clock    (clock),
        .clear    (clear),
        .IR       (IR),
        .stop     (stop),
        .PCout    (PCout),
        .PCin     (PCin),
        .IncPC    (IncPC),
        .MARin    (MARin),
        .Read     (Read),
        .MDRin    (MDRin),
        .MDRout   (MDRout),
        .IRin     (IRin),
        .Yin      (Yin),
        .Zin      (Zin),
        .Zlowout  (Zlowout),
        .Zhighout (Zhighout),
        .HIin     (HIin),
        .LOin     (LOin),
        .Gra      (Gra),
        .Grb      (Grb),
        .Grc      (Grc),
        .Rin      (Rin),
        .Rout     (Rout),
        .alu_op   (alu_op),
        .run      (run),
        .state    (state)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    wire [27:0] obs = {PCout, PCin, IncPC, MARin, Read, MDRin, MDRout,
                       IRin, Yin, Zin, Zlowout, Zhighout, HIin, LOin,
                       Gra, Grb, Grc, Rin, Rout, alu_op, run, state};

    function automatic logic [27:0] mk(int st, logic [18:0] s, int alu);
        logic r;
        r = (st != S_RST) && (st != S_HALT);
        return {s, 4'(alu), r, 4'(st)};
    endfunction

    // Position in the ALU table, or -1 when the opcode is not an ALU op
    // in this build.
    function automatic int alu_index(logic [4:0] op);
        for (int k = 0; k < 13; k++)
            if (alu_ops[k] == op) begin
                if ((k == 9 || k == 10) && !MD_BUILD)
                    return -1;
                return k;
            end
        return -1;
    endfunction

    // Expected per-cycle trace of one instruction starting in T0.
    task automatic build_trace(input logic [4:0] op);
        int k;
        bit md;
        bit un;
        exp_q.delete();
        exp_q.push_back(mk(S_T0, B_PCOUT | B_MARIN | B_INCPC | B_ZIN, 0));
        exp_q.push_back(mk(S_T1, B_ZLO | B_PCIN | B_READ | B_MDRIN, 0));
        exp_q.push_back(mk(S_T2, B_MDROUT | B_IRIN, 0));
        k = alu_index(op);
        if (k < 0) begin
            exp_q.push_back(mk(S_T3, '0, 0));
            exp_ends_halt = (op != 5'b11011);
        end else begin
            md = (k == 9) || (k == 10);
            un = (k >= 11);
            exp_ends_halt = 1'b0;
            exp_q.push_back(mk(S_T3, B_GRB | B_ROUT | B_YIN, 0));
            exp_q.push_back(mk(S_T4, B_ROUT | (un ? B_GRB : B_GRC) | B_ZIN,
                               k));
            exp_q.push_back(mk(S_T5, B_ZLO | (md ? B_LOIN : (B_GRA | B_RIN)),
                               0));
            if (md)
                exp_q.push_back(mk(S_T6, B_ZHI | B_HIIN, 0));
        end
    endtask

    task automatic check(input string tag, input logic [27:0] e);
        vectors++;
        assert (obs === e) else begin
            miscompares++;
            $error("FAIL %s: observed %h, expected %h (t=%0t)",
                   tag, obs, e, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Runs one instruction from T0; pat: 0 stop low, 1 high in T1 only,
    // 2 always high, 3 random.
    task automatic run_instr(input string tag, input logic [31:0] ir,
                             input int pat, output bit halted);
        bit s_final;
        int n;
        IR = ir;
        build_trace(ir[31:27]);
        n = exp_q.size();
        s_final = 1'b0;
        for (int i = 0; i < n; i++) begin
            case (pat)
                0:       stop = 1'b0;
                1:       stop = (i == 1);
                2:       stop = 1'b1;
                default: stop = ($urandom_range(0, 3) == 0);
            endcase
            if (i == n - 1)
                s_final = stop;
            check($sformatf("%s_c%0d", tag, i), exp_q[i]);
            tick();
        end
        halted = exp_ends_halt || s_final;
        check($sformatf("%s_next", tag),
              halted ? mk(S_HALT, '0, 0)
                     : mk(S_T0, B_PCOUT | B_MARIN | B_INCPC | B_ZIN, 0));
        stop = 1'b0;
    endtask

    task automatic hold_halt(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            stop = 1'($urandom);
            check($sformatf("%s_h%0d", tag, i), mk(S_HALT, '0, 0));
            tick();
        end
        stop = 1'b0;
    endtask

    // Called at posedge+1; asserts clear mid-cycle.
    task automatic do_reset(input string tag);
        #3;
        clear = 1'b0;
        #1;
        check({tag, "_async"}, mk(S_RST, '0, 0));
        tick();
        check({tag, "_held"}, mk(S_RST, '0, 0));
        @(negedge clock);
        clear = 1'b1;
        tick();
        check({tag, "_t0"}, mk(S_T0, B_PCOUT | B_MARIN | B_INCPC | B_ZIN, 0));
    endtask

    initial begin
        bit h;
        logic [4:0] op;
        clear = 1'b0;
        IR    = '0;
        stop  = 1'b0;
        #1;
        check("por", mk(S_RST, '0, 0));
        tick();
        check("por_held", mk(S_RST, '0, 0));
        @(negedge clock);
        clear = 1'b1;
        tick();
        check("release", mk(S_T0, B_PCOUT | B_MARIN | B_INCPC | B_ZIN, 0));

        run_instr("add", 32'h18918000, 0, h);
        if (h) do_reset("add_rst");
        run_instr("and_pulse", 32'h28000000, 1, h);
        if (h) do_reset("and_pulse_rst");
        run_instr("and_stop", 32'h28000000, 2, h);
        hold_halt("and_stop", 10);
        do_reset("and_stop_rst");
        run_instr("nop", 32'hD8000000, 0, h);
        if (h) do_reset("nop_rst");
        run_instr("nop_stop", 32'hD8000000, 2, h);
        hold_halt("nop_stop", 3);
        do_reset("nop_stop_rst");
        run_instr("halt", 32'hE0000000, 0, h);
        hold_halt("halt", 3);
        do_reset("halt_rst");
        run_instr("mul", 32'h78000000, 0, h);
        if (h) begin
            hold_halt("mul", 10);
            do_reset("mul_rst");
        end
        run_instr("div", 32'h80000000, 2, h);
        if (h) do_reset("div_rst");
        run_instr("neg", 32'h88000000, 0, h);
        if (h) do_reset("neg_rst");
        run_instr("not", 32'h90000000, 0, h);
        if (h) do_reset("not_rst");

        IR = 32'h18918000;
        stop = 1'b0;
        for (int i = 0; i < 4; i++)
            tick();
        check("mid_t4", mk(S_T4, B_ROUT | B_GRC | B_ZIN, 0));
        do_reset("mid_t4_rst");

        for (int n = 0; n < 300; n++) begin
            if ($urandom_range(0, 3) == 0)
                op = 5'($urandom);
            else
                op = alu_ops[$urandom_range(0, 12)];
            if ($urandom_range(0, 9) == 0)
                op = 5'b11011;
            run_instr($sformatf("rnd%0d", n), {op, 27'($urandom)},
                      $urandom_range(0, 3), h);
            if (h) begin
                hold_halt($sformatf("rnd%0d", n), 2);
                do_reset($sformatf("rnd%0d_rst", n));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
